// File: rtl/pixel_tap_line_pkg.sv
// Shared defaults and width helpers for the pixel tap line.
package pixel_tap_line_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 19;

    // Width of a 0-based tap index.
    function automatic int unsigned sel_width(input int unsigned depth);
        return 32'($clog2(depth));
    endfunction

    // Width of a counter that must reach depth itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return 32'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/pixel_tap_line_tap_stage.sv
// One tap of the line: a pixel register plus its valid flag.
module tap_stage
    import pixel_tap_line_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] d,
    input  logic              d_valid,
    output logic [DATA_W-1:0] q,
    output logic              q_valid
);

    // Load wins over flush so the head stage can take a pixel on a line start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= d;
            q_valid <= d_valid;
        end else if (flush) begin
            q       <= '0;
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_tap_line.sv
// Shift-register line of pixel taps with fill tracking and a registered tap selector.
module pixel_tap_line
    import pixel_tap_line_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned SEL_W  = sel_width(DEPTH),
    localparam int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    clear,
    input  logic [SEL_W-1:0]        sel,
    output logic [DEPTH*DATA_W-1:0] taps,
    output logic [DEPTH-1:0]        tap_valid,
    output logic [CNT_W-1:0]        fill_cnt,
    output logic                    full,
    output logic [DATA_W-1:0]       sel_data,
    output logic                    sel_valid
);

    logic [DATA_W-1:0] tap_q [DEPTH];
    logic [DEPTH-1:0]  tap_v;

    // Head takes in_data even on clear; body stages only shift when not clearing.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            tap_stage #(.DATA_W(DATA_W)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (in_valid),
                .flush   (clear),
                .d       (in_data),
                .d_valid (1'b1),
                .q       (tap_q[k]),
                .q_valid (tap_v[k])
            );
        end else begin : g_body
            tap_stage #(.DATA_W(DATA_W)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (in_valid & ~clear),
                .flush   (clear),
                .d       (tap_q[k-1]),
                .d_valid (tap_v[k-1]),
                .q       (tap_q[k]),
                .q_valid (tap_v[k])
            );
        end
        assign taps[k*DATA_W +: DATA_W] = tap_q[k];
    end

    assign tap_valid = tap_v;
    assign full      = (fill_cnt == CNT_W'(DEPTH));

    // Saturating count of valid taps; a clear with a pixel restarts at one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (clear) begin
            fill_cnt <= in_valid ? CNT_W'(1) : '0;
        end else if (in_valid && !full) begin
            fill_cnt <= fill_cnt + CNT_W'(1);
        end
    end

    // Registered tap selector; indices past the last tap read as empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_data  <= '0;
            sel_valid <= 1'b0;
        end else if (CNT_W'(sel) < CNT_W'(DEPTH)) begin
            sel_data  <= tap_q[sel];
            sel_valid <= tap_v[sel];
        end else begin
            sel_data  <= '0;
            sel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_tap_line.sv
// Scoreboard bench for pixel_tap_line: a reference model predicts every output each cycle.
module tb_pixel_tap_line;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 19;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned TW     = DEPTH * DATA_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [DATA_W-1:0]   in_data = '0;
    logic                clear = 1'b0;
    logic [SEL_W-1:0]    sel = '0;
    logic [TW-1:0]       taps;
    logic [DEPTH-1:0]    tap_valid;
    logic [CNT_W-1:0]    fill_cnt;
    logic                full;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_valid;

    pixel_tap_line #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .sel       (sel),
        .taps      (taps),
        .tap_valid (tap_valid),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .sel_data  (sel_data),
        .sel_valid (sel_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0]     taps;
        logic [DEPTH-1:0]  vld;
        logic [CNT_W-1:0]  cnt;
        logic              full;
        logic [DATA_W-1:0] sd;
        logic              sv;
    } exp_t;

    exp_t exp_q[$];

    logic [DATA_W-1:0] m_tap [DEPTH];
    logic [DEPTH-1:0]  m_vld = '0;
    int unsigned       m_cnt = 0;
    logic [DATA_W-1:0] m_sd = '0;
    logic              m_sv = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] dut_tap(input int k);
        return taps[(k-1)*DATA_W +: DATA_W];
    endfunction

    // Advance the reference model by one clock edge from the given inputs.
    task automatic model_edge(input logic r, input logic v, input logic [DATA_W-1:0] d,
                              input logic c, input logic [SEL_W-1:0] s);
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) m_tap[i] = '0;
            m_vld = '0; m_cnt = 0; m_sd = '0; m_sv = 1'b0;
            return;
        end
        if (int'(s) < DEPTH) begin
            m_sd = m_tap[s]; m_sv = m_vld[s];
        end else begin
            m_sd = '0; m_sv = 1'b0;
        end
        if (c) begin
            for (int i = 0; i < DEPTH; i++) m_tap[i] = '0;
            m_vld = '0; m_cnt = 0;
            if (v) begin
                m_tap[0] = d; m_vld[0] = 1'b1; m_cnt = 1;
            end
        end else if (v) begin
            for (int i = DEPTH - 1; i > 0; i--) m_tap[i] = m_tap[i-1];
            m_tap[0] = d;
            m_vld = {m_vld[DEPTH-2:0], 1'b1};
            if (m_cnt < DEPTH) m_cnt++;
        end
    endtask

    // Drive one cycle, queue the prediction, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                        input logic c, input logic [SEL_W-1:0] s);
        exp_t e;
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; clear = c; sel = s;
        model_edge(r, v, d, c, s);
        for (int i = 0; i < DEPTH; i++) e.taps[i*DATA_W +: DATA_W] = m_tap[i];
        e.vld = m_vld; e.cnt = CNT_W'(m_cnt); e.full = (m_cnt == DEPTH);
        e.sd = m_sd; e.sv = m_sv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("taps", taps, e.taps);
        check("tap_valid", TW'(tap_valid), TW'(e.vld));
        check("fill_cnt", TW'(fill_cnt), TW'(e.cnt));
        check("full", TW'(full), TW'(e.full));
        check("sel_data", TW'(sel_data), TW'(e.sd));
        check("sel_valid", TW'(sel_valid), TW'(e.sv));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 8'hEE, 1'b1, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_tap[i] = '0;

        // Reset state, with clear and in_valid active to show reset wins
        do_reset();
        check("rst_taps", taps, '0);
        check("rst_full", TW'(full), '0);

        // Fill with 1..19
        for (int i = 1; i <= 19; i++) step(1'b1, 1'b1, DATA_W'(i), 1'b0, '0);
        check("fill_tap1", TW'(dut_tap(1)), TW'(19));
        check("fill_tap10", TW'(dut_tap(10)), TW'(10));
        check("fill_tap19", TW'(dut_tap(19)), TW'(1));
        check("fill_cnt19", TW'(fill_cnt), TW'(19));
        check("fill_full", TW'(full), TW'(1));
        check("fill_vld", TW'(tap_valid), TW'(19'h7FFFF));

        // Overflow: oldest discarded, count saturates
        step(1'b1, 1'b1, 8'd20, 1'b0, '0);
        step(1'b1, 1'b1, 8'd21, 1'b0, '0);
        check("ovf_tap1", TW'(dut_tap(1)), TW'(21));
        check("ovf_tap19", TW'(dut_tap(19)), TW'(3));
        check("ovf_cnt", TW'(fill_cnt), TW'(19));

        // Alternating valid: five shifts only
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, (i % 2 == 0), DATA_W'(8'hA0 + i), 1'b0, '0);
        check("alt_cnt", TW'(fill_cnt), TW'(5));
        check("alt_tap1", TW'(dut_tap(1)), TW'(8'hA8));
        check("alt_tap5", TW'(dut_tap(5)), TW'(8'hA0));
        check("alt_vld", TW'(tap_valid), TW'(19'h1F));

        // Clear with a sample after seven fills
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, DATA_W'(8'h30 + i), 1'b0, '0);
        step(1'b1, 1'b1, 8'h55, 1'b1, '0);
        check("clr_tap1", TW'(dut_tap(1)), TW'(8'h55));
        check("clr_rest", taps >> DATA_W, '0);
        check("clr_cnt", TW'(fill_cnt), TW'(1));
        check("clr_full", TW'(full), '0);
        check("clr_vld", TW'(tap_valid), TW'(1));
        step(1'b1, 1'b0, 8'h77, 1'b1, '0);
        check("clr_idle_taps", taps, '0);
        check("clr_idle_cnt", TW'(fill_cnt), '0);

        // Selector: tap5 then out-of-range indices
        do_reset();
        for (int i = 1; i <= 19; i++) step(1'b1, 1'b1, DATA_W'(i), 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 5'd4);
        check("sel4_data", TW'(sel_data), TW'(15));
        check("sel4_valid", TW'(sel_valid), TW'(1));
        step(1'b1, 1'b0, '0, 1'b0, 5'd19);
        check("sel19_data", TW'(sel_data), '0);
        check("sel19_valid", TW'(sel_valid), '0);
        step(1'b1, 1'b0, '0, 1'b0, 5'd18);
        check("sel18_data", TW'(sel_data), TW'(1));
        step(1'b1, 1'b1, 8'h99, 1'b0, 5'd0);
        check("sel_lat_old", TW'(sel_data), TW'(19));
        step(1'b1, 1'b0, '0, 1'b0, 5'd0);
        check("sel_lat_new", TW'(sel_data), TW'(8'h99));
        step(1'b1, 1'b0, '0, 1'b0, 5'd31);
        check("sel31_valid", TW'(sel_valid), '0);

        // Reset mid-fill
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DATA_W'(8'h60 + i), 1'b0, 5'd2);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 5'd2);
        check("mrst_taps", taps, '0);
        check("mrst_cnt", TW'(fill_cnt), '0);
        check("mrst_sel", TW'(sel_data), '0);
        step(1'b1, 1'b1, 8'h42, 1'b0, 5'd2);
        check("mrst_cnt1", TW'(fill_cnt), TW'(1));
        check("mrst_tap1", TW'(dut_tap(1)), TW'(8'h42));

        // Random traffic against the model
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
                 DATA_W'($urandom), ($urandom_range(0, 24) == 0),
                 SEL_W'($urandom_range(0, 31)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_tap_line.md
PIXEL_TAP_LINE -- requirements
Module: pixel_tap_line

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one pixel sample.
REQ-002 SHALL have parameter DEPTH, default 19, number of tap stages; legal range 2..64.
REQ-003 SHALL use one clock; reset is synchronous and active-low; ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  qualifies in_data; shift occurs only when high.
REQ-007 in_data  in  DATA_W  incoming pixel.
REQ-008 clear  in  1  synchronous flush (line start).
REQ-009 sel  in  SEL_W=clog2(DEPTH)  0-based index of tap routed to sel_data.
REQ-010 taps  out  DEPTH*DATA_W  all tap registers; tap k (k=1..DEPTH) at bits [k*DATA_W-1 -: DATA_W].
REQ-011 tap_valid  out  DEPTH  bit k-1 high when tap k holds a sample written since the last reset/clear.
REQ-012 fill_cnt  out  CNT_W=clog2(DEPTH+1)  number of valid taps, saturating at DEPTH.
REQ-013 full  out  1  high when fill_cnt == DEPTH.
REQ-014 sel_data  out  DATA_W  registered copy of tap[sel+1].
REQ-015 sel_valid  out  1  registered copy of tap_valid[sel]; 0 when sel out of range.

Function
REQ-016 in_valid=1, clear=0: tap1 <= in_data, tap k <= tap k-1 for k=2..DEPTH, tap_valid shifts likewise with bit0 <= 1, all in one cycle.
REQ-017 in_valid=0, clear=0: taps, tap_valid, fill_cnt hold.
REQ-018 fill_cnt increments by 1 per accepted sample until DEPTH, then holds at DEPTH (no wrap).
REQ-019 clear=1, in_valid=0: all taps <= 0, tap_valid <= 0, fill_cnt <= 0.
REQ-020 clear=1, in_valid=1: taps 2..DEPTH <= 0, tap1 <= in_data, tap_valid <= 1 (bit0 only), fill_cnt <= 1.
REQ-021 Oldest sample (tap DEPTH) is discarded on shift; no overflow flag.
REQ-022 sel_data/sel_valid SHALL update each cycle from pre-edge tap registers and sel: one-cycle latency from tap change to sel_data change.
REQ-023 sel >= DEPTH: sel_data <= 0, sel_valid <= 0.
REQ-024 full SHALL be combinational from fill_cnt, no extra latency.
REQ-025 No combinational path from in_data/in_valid/clear to any output.

Reset
REQ-026 rst_n=0 at a rising edge: all taps, tap_valid, fill_cnt, sel_data, sel_valid <= 0, full = 0; overrides clear and in_valid.
REQ-027 Reset asserted mid-fill SHALL discard all contents; first sample after release lands in tap1 with fill_cnt=1.

Structure
REQ-028 Shared package SHALL hold default DATA_W/DEPTH constants and the clog2-based SEL_W/CNT_W width functions.
REQ-029 One sub-module tap_stage (one DATA_W register plus valid bit with shift/clear/reset) SHALL be instantiated DEPTH times via generate.
REQ-030 Fill counter and sel mux SHALL live in the top level.

Verification
REQ-031 Reset then in_valid=1 for 19 cycles, in_data=1..19 -> tap k = 20-k, fill_cnt=19, full=1, tap_valid=all ones.
REQ-032 Continue with in_data=20,21 -> tap1=21, tap19=3, fill_cnt stays 19.
REQ-033 Alternate in_valid 1/0 over 10 cycles, data 0xA0.. -> only 5 shifts, taps hold on idle cycles, fill_cnt=5.
REQ-034 After 7 samples assert clear with in_valid=1, in_data=0x55 -> tap1=0x55, taps 2..19=0, fill_cnt=1, full=0.
REQ-035 sel=4 then sel=19 (DEPTH=19) -> sel_data=tap5 one cycle later; then sel_data=0, sel_valid=0.
REQ-036 rst_n=0 for one cycle after 10 samples -> all outputs 0 next edge; next sample gives fill_cnt=1.
